cu_mc: RTL and testbench
========================

Name: cu_mc

Overview:
- Multi-cycle control unit for the mycpu datapath, and the next generation of the current fixed-width decoder.
- Decodes the instruction held in the external IR into datapath control words.
- Adds three things:
  - a parametrised register-address width;
  - a memory/IO ready handshake with wait states and a timeout;
  - resumable halt.
- Sits between the IR/status flags and the datapath, register file and memory/IO bus.

Parameters:
- RA_W, 3: register address field width; instruction width is 7+3*RA_W.
- WAIT_MAX, 15: maximum MWT cycles before timeout, range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ins_in  in  7+3*RA_W  instruction; opcode = ins_in[MSB-:7]; fields DA, AA, BA follow, MSB first
- z_in  in  1  zero flag
- n_in  in  1  negative flag
- mem_rdy_in  in  1  memory/IO ready for the current access
- run_in  in  1  resume request from HLT
- il_out  out  1  IR load
- ps_out  out  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump
- rw_out  out  1  register write enable
- rs_out  out  3*(RA_W+1)  {1'b0,DA,1'b0,AA,1'b0,BA}
- mm_out  out  1  address mux select
- md_out  out  2  write-back select: 00 ALU, 01 memory, 10 IO
- mb_out  out  1  immediate select
- fs_out  out  4  ALU function
- wen_out  out  1  memory write enable, active-low
- iom_out  out  1  IO space select
- halted_out  out  1  high in HLT
- err_out  out  1  sticky bus-timeout flag

Behaviour:
- States: RST, INF, EX0, MWT, HLT.
- Next-state registers are the only flops besides the wait counter and err.
- Reset (asynchronous) forces RST, clears the counter and err.
- Reset-state outputs: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0, wen=1, iom=0, halted=0, err=0.
- rst_n mid-access aborts immediately; no partial write completes beyond the current cycle.
- RST: outputs at reset values; next state INF.
- INF: il=1, all else at reset values; next state EX0.
- EX0, non-memory opcodes, one cycle, next state INF (HAL: next state HLT):
  - ps_out:
    - BRZ: 10 if z_in=1, else 01.
    - BRN: 10 if n_in=1, else 01.
    - JMP: 11.
    - HAL and XXL: 00.
    - All others: 01.
  - rw=0 for ST, BRZ, BRN, JMP, IOW, HAL, XXL; otherwise rw=1.
  - mb=1 for LDI and ADI.
  - fs=opcode[3:0]; 0000 for BRN.
  - mm=0.
- Memory-class opcodes (LD, ST, IOR, IOW) in EX0 and MWT:
  - Every cycle, rs, md, wen (0 for ST/IOW), iom (1 for IOR/IOW) and fs are driven as decoded.
  - If mem_rdy_in=1, the access completes this cycle: ps=01, rw=1 for LD/IOR, next state INF.
  - Otherwise ps=00, rw=0, next state MWT.
  - A zero-wait access therefore completes in EX0.
- Wait counter:
  - Cleared on entry to MWT; incremented each MWT cycle without ready.
  - If the counter equals WAIT_MAX-1 and mem_rdy_in=0: next state HLT, err set.
  - wen forced to 1 in that timeout cycle's successor, i.e. HLT.
- HLT: outputs at reset values except halted=1 and err held.
  - run_in=1: next state INF; err cleared.
- The ready/timeout rule applies at the same edge: ready in the last allowed cycle wins, with no error.
- All outputs are combinational from state and inputs.
- ins_in must be stable from the INF edge until the instruction completes.

Optional Feature:
- CU_IRQ_EN: adds port irq_in (in, 1), port irq_ack_out (out, 1) and state IRQ.
  - irq_armed_r is set at reset and cleared on IRQ entry.
  - irq_armed_r is re-set when any EX0 or MWT instruction completes.
  - In INF with irq_in=1 and irq_armed_r=1: il=0, next state IRQ.
  - IRQ: ps=11, irq_ack_out=1, all else at reset values; next state INF.
  - HLT with irq_in=1 also goes to IRQ.
- Without the macro, none of these ports or states exist and INF always proceeds to EX0.

Decomposition:
- Extend mycpu_pkg with:
  - cu_mc_state_t;
  - the PS_HOLD/PS_INC/PS_BR/PS_JMP and MD_ALU/MD_MEM/MD_IO constants;
  - the is_mem_op() function.
  - opcode_t stays in the package.
- One sub-module, cu_mc_dec: a purely combinational opcode-to-control-word decoder.
- The FSM, wait counter and err stay in the top level.

Test Plan:
- Reset then ADD with ins fields DA=1, AA=2, BA=3 -> INF il=1; EX0 rw=1, ps=01, rs=0001_0010_0011, fs=ADD[3:0]; back to INF.
- BRZ with z=1, then BRN with n=0 -> ps=10, then ps=01; rw=0 both.
- LD with mem_rdy low for 3 cycles -> 3 MWT cycles with ps=00, rw=0, md=01; ready cycle rw=1, ps=01; then INF.
- ST with mem_rdy never high, WAIT_MAX=4 -> wen=0 for 5 cycles (EX0 plus 4 MWT), then HLT with err=1, halted=1; run_in pulse -> INF with err=0.
- HAL -> HLT holds indefinitely with ps=00; rst_n asserted mid-MWT -> all outputs at reset values in the same cycle.
- CU_IRQ_EN: irq_in held high -> exactly one IRQ with ps=11, irq_ack=1; the next IRQ is taken only after one instruction completes.

Source files
------------

// File: rtl/cu_mc_pkg.sv
// Shared types for the multi-cycle mycpu control unit: opcodes, FSM states,
// control-word encodings. CU_IRQ_EN adds the IRQ state.
package cu_mc_pkg;

    typedef enum logic [6:0] {
        OP_MOVA = 7'b0000000,
        OP_INC  = 7'b0000001,
        OP_ADD  = 7'b0000010,
        OP_SUB  = 7'b0000101,
        OP_DEC  = 7'b0000110,
        OP_AND  = 7'b0001000,
        OP_OR   = 7'b0001001,
        OP_XOR  = 7'b0001010,
        OP_NOT  = 7'b0001011,
        OP_MOVB = 7'b0001100,
        OP_SHR  = 7'b0001101,
        OP_SHL  = 7'b0001110,
        OP_LD   = 7'b0010000,
        OP_IOR  = 7'b0010001,
        OP_ST   = 7'b0100000,
        OP_IOW  = 7'b0100001,
        OP_ADI  = 7'b1000010,
        OP_LDI  = 7'b1001100,
        OP_BRZ  = 7'b1100000,
        OP_BRN  = 7'b1100001,
        OP_JMP  = 7'b1110000,
        OP_XXL  = 7'b1111110,
        OP_HAL  = 7'b1111111
    } opcode_t;

    typedef enum logic [2:0] {
        S_RST,
        S_INF,
        S_EX0,
        S_MWT,
        S_HLT
`ifdef CU_IRQ_EN
        , S_IRQ
`endif
    } cu_mc_state_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_IO  = 2'b10;

    // Control word for an instruction that completes in the current cycle.
    typedef struct packed {
        logic [1:0] ps;
        logic       rw;
        logic       mm;
        logic [1:0] md;
        logic       mb;
        logic [3:0] fs;
        logic       wen;
        logic       iom;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_IOR) || (op == OP_IOW);
    endfunction

endpackage

// File: rtl/cu_mc_if.sv
// Control-unit bus: IR/flags/handshake in, datapath control words out.
// CU_IRQ_EN adds the interrupt request/acknowledge pair.
interface cu_mc_if #(parameter int RA_W = 3);

    logic [7+3*RA_W-1:0]   ins_in;
    logic                  z_in;
    logic                  n_in;
    logic                  mem_rdy_in;
    logic                  run_in;
    logic                  il_out;
    logic [1:0]            ps_out;
    logic                  rw_out;
    logic [3*(RA_W+1)-1:0] rs_out;
    logic                  mm_out;
    logic [1:0]            md_out;
    logic                  mb_out;
    logic [3:0]            fs_out;
    logic                  wen_out;
    logic                  iom_out;
    logic                  halted_out;
    logic                  err_out;
`ifdef CU_IRQ_EN
    logic                  irq_in;
    logic                  irq_ack_out;
`endif

    modport master (
        input  ins_in, z_in, n_in, mem_rdy_in, run_in,
        output il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
               fs_out, wen_out, iom_out, halted_out, err_out
`ifdef CU_IRQ_EN
        , input irq_in, output irq_ack_out
`endif
    );

    modport slave (
        output ins_in, z_in, n_in, mem_rdy_in, run_in,
        input  il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
               fs_out, wen_out, iom_out, halted_out, err_out
`ifdef CU_IRQ_EN
        , output irq_in, input irq_ack_out
`endif
    );

endinterface

// File: rtl/cu_mc_dec.sv
// Combinational opcode decoder: control word assuming the instruction
// completes this cycle. Unrecognised opcodes decode as XXL.
module cu_mc_dec
    import cu_mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic       z,
    input  logic       n,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.ps  = PS_INC;
        ctrl.rw  = 1'b1;
        ctrl.md  = MD_ALU;
        ctrl.fs  = op[3:0];
        ctrl.wen = 1'b1;
        ctrl.mm  = is_mem_op(op);
        case (op)
            OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL: ;
            OP_LDI, OP_ADI: ctrl.mb = 1'b1;
            OP_LD:  ctrl.md = MD_MEM;
            OP_IOR: begin
                ctrl.md  = MD_IO;
                ctrl.iom = 1'b1;
            end
            OP_ST: begin
                ctrl.rw  = 1'b0;
                ctrl.wen = 1'b0;
            end
            OP_IOW: begin
                ctrl.rw  = 1'b0;
                ctrl.wen = 1'b0;
                ctrl.iom = 1'b1;
            end
            OP_BRZ: begin
                ctrl.rw = 1'b0;
                ctrl.ps = z ? PS_BR : PS_INC;
            end
            OP_BRN: begin
                ctrl.rw = 1'b0;
                ctrl.ps = n ? PS_BR : PS_INC;
                ctrl.fs = 4'b0000;
            end
            OP_JMP: begin
                ctrl.rw = 1'b0;
                ctrl.ps = PS_JMP;
            end
            default: begin
                ctrl.rw = 1'b0;
                ctrl.ps = PS_HOLD;
            end
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// Multi-cycle control unit: fetch/execute FSM with memory wait states,
// bus timeout and resumable halt. CU_IRQ_EN adds a single-shot IRQ state.
//
// state | meaning
// RST   | post-reset idle, outputs at reset values
// INF   | load IR
// EX0   | execute; memory ops start their access here
// MWT   | memory/IO wait state, counted for timeout
// HLT   | halted, waits for run_in (bus timeout also lands here)
// IRQ   | jump to interrupt vector (CU_IRQ_EN only)
module cu_mc
    import cu_mc_pkg::*;
#(
    parameter int RA_W     = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic      clk,
    input  logic      rst_n,
    cu_mc_if.master   bus
);

    localparam int         IW        = 7 + 3*RA_W;
    localparam logic [7:0] WCNT_LAST = 8'(WAIT_MAX - 1);

    logic [6:0]      op;
    logic [RA_W-1:0] da, aa, ba;
    logic            mem_op;
    ctrl_t           dec;

    cu_mc_state_t state, state_nx;
    logic [7:0]   wcnt, wcnt_nx;
    logic         err, err_nx;

    assign op     = bus.ins_in[IW-1 -: 7];
    assign da     = bus.ins_in[3*RA_W-1 -: RA_W];
    assign aa     = bus.ins_in[2*RA_W-1 -: RA_W];
    assign ba     = bus.ins_in[RA_W-1:0];
    assign mem_op = is_mem_op(op);

    cu_mc_dec u_dec (
        .op   (op),
        .z    (bus.z_in),
        .n    (bus.n_in),
        .ctrl (dec)
    );

`ifdef CU_IRQ_EN
    logic irq_armed_r, irq_armed_nx, done;
    assign done = ((state == S_EX0) || (state == S_MWT)) && (!mem_op || bus.mem_rdy_in);
`endif

    always_comb begin
        state_nx       = state;
        wcnt_nx        = wcnt;
        err_nx         = err;
        bus.il_out     = 1'b0;
        bus.ps_out     = PS_HOLD;
        bus.rw_out     = 1'b0;
        bus.rs_out     = '0;
        bus.mm_out     = 1'b0;
        bus.md_out     = MD_ALU;
        bus.mb_out     = 1'b0;
        bus.fs_out     = 4'b0000;
        bus.wen_out    = 1'b1;
        bus.iom_out    = 1'b0;
        bus.halted_out = 1'b0;
        bus.err_out    = err;
`ifdef CU_IRQ_EN
        bus.irq_ack_out = 1'b0;
`endif
        case (state)
            S_RST: state_nx = S_INF;
            S_INF: begin
                bus.il_out = 1'b1;
                state_nx   = S_EX0;
`ifdef CU_IRQ_EN
                if (bus.irq_in && irq_armed_r) begin
                    bus.il_out = 1'b0;
                    state_nx   = S_IRQ;
                end
`endif
            end
            S_EX0, S_MWT: begin
                bus.rs_out  = {1'b0, da, 1'b0, aa, 1'b0, ba};
                bus.mm_out  = dec.mm;
                bus.md_out  = dec.md;
                bus.mb_out  = dec.mb;
                bus.fs_out  = dec.fs;
                bus.wen_out = dec.wen;
                bus.iom_out = dec.iom;
                if (!mem_op || bus.mem_rdy_in) begin
                    bus.ps_out = dec.ps;
                    bus.rw_out = dec.rw;
                    state_nx   = (op == OP_HAL) ? S_HLT : S_INF;
                end else if (state == S_EX0) begin
                    state_nx = S_MWT;
                    wcnt_nx  = '0;
                end else if (wcnt == WCNT_LAST) begin
                    // Timeout: the write strobe drops as HLT is entered.
                    state_nx = S_HLT;
                    err_nx   = 1'b1;
                end else begin
                    wcnt_nx = wcnt + 8'd1;
                end
            end
            S_HLT: begin
                bus.halted_out = 1'b1;
                if (bus.run_in) begin
                    state_nx = S_INF;
                    err_nx   = 1'b0;
                end
`ifdef CU_IRQ_EN
                if (bus.irq_in) state_nx = S_IRQ;
`endif
            end
`ifdef CU_IRQ_EN
            S_IRQ: begin
                bus.ps_out      = PS_JMP;
                bus.irq_ack_out = 1'b1;
                state_nx        = S_INF;
            end
`endif
            default: state_nx = S_RST;
        endcase
    end

`ifdef CU_IRQ_EN
    always_comb begin
        irq_armed_nx = irq_armed_r;
        if (done) irq_armed_nx = 1'b1;
        if (state_nx == S_IRQ && state != S_IRQ) irq_armed_nx = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            wcnt  <= '0;
            err   <= 1'b0;
`ifdef CU_IRQ_EN
            irq_armed_r <= 1'b1;
`endif
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            err   <= err_nx;
`ifdef CU_IRQ_EN
            irq_armed_r <= irq_armed_nx;
`endif
        end
    end

endmodule

// File: tb/tb_cu_mc.sv
// Scoreboard bench for cu_mc (RA_W=3, WAIT_MAX=4); the IRQ sequence runs
// only when CU_IRQ_EN is defined.
module tb_cu_mc;
    import cu_mc_pkg::*;

    typedef struct packed {
        logic        il;
        logic [1:0]  ps;
        logic        rw;
        logic [11:0] rs;
        logic        mm;
        logic [1:0]  md;
        logic        mb;
        logic [3:0]  fs;
        logic        wen;
        logic        iom;
        logic        halted;
        logic        err;
        logic        ack;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    obs_t  exp_q[$];
    string name_q[$];

    cu_mc_if #(.RA_W(3)) bus ();

    cu_mc #(.RA_W(3), .WAIT_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic il, input logic [1:0] ps, input logic rw,
                               input logic [11:0] rs, input logic mm, input logic [1:0] md,
                               input logic mb, input logic [3:0] fs, input logic wen,
                               input logic iom, input logic halted, input logic err,
                               input logic ack);
        return {il, ps, rw, rs, mm, md, mb, fs, wen, iom, halted, err, ack};
    endfunction

    function automatic logic [15:0] mk(input opcode_t op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b};
    endfunction

    function automatic logic [11:0] rsv(input logic [2:0] d, input logic [2:0] a,
                                        input logic [2:0] b);
        return {1'b0, d, 1'b0, a, 1'b0, b};
    endfunction

    obs_t RSTV, INFV, HLTV, HLTE;
    initial begin
        RSTV = o(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0, 0);
        INFV = o(1, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0, 0);
        HLTV = o(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 1, 0, 0);
        HLTE = o(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 1, 1, 0);
    end

    // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
    always @(negedge clk) begin
        obs_t  act, e;
        string nm;
        logic  ack;
`ifdef CU_IRQ_EN
        ack = bus.irq_ack_out;
`else
        ack = 1'b0;
`endif
        act = {bus.il_out, bus.ps_out, bus.rw_out, bus.rs_out, bus.mm_out, bus.md_out,
               bus.mb_out, bus.fs_out, bus.wen_out, bus.iom_out, bus.halted_out,
               bus.err_out, ack};
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", nm, act, e);
            end
        end
    end

    task automatic cyc(input logic [15:0] ins, input logic z, input logic n,
                       input logic rdy, input logic run, input obs_t e, input string nm);
        bus.ins_in     = ins;
        bus.z_in       = z;
        bus.n_in       = n;
        bus.mem_rdy_in = rdy;
        bus.run_in     = run;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ins;
        bus.ins_in = '0; bus.z_in = 0; bus.n_in = 0; bus.mem_rdy_in = 0; bus.run_in = 0;
`ifdef CU_IRQ_EN
        bus.irq_in = 1'b0;
`endif
        @(posedge clk); #1;
        cyc(16'h0, 0, 0, 0, 0, RSTV, "reset_hold");
        rst_n = 1'b1;
        cyc(16'h0, 0, 0, 0, 0, RSTV, "rst_state");

        ins = mk(OP_ADD, 3'd1, 3'd2, 3'd3);
        cyc(ins, 0, 0, 0, 0, INFV, "add_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b01, 1, 12'h123, 0, 2'b00, 0, 4'b0010, 1, 0, 0, 0, 0), "add_ex0");

        ins = mk(OP_BRZ, 3'd0, 3'd0, 3'd0);
        cyc(ins, 1, 0, 0, 0, INFV, "brz_inf");
        cyc(ins, 1, 0, 0, 0, o(0, 2'b10, 0, 12'h000, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0, 0), "brz_taken");
        ins = mk(OP_BRN, 3'd2, 3'd0, 3'd0);
        cyc(ins, 0, 0, 0, 0, INFV, "brn_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b01, 0, 12'h200, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0, 0), "brn_not_taken");
        cyc(ins, 0, 1, 0, 0, INFV, "brn_inf2");
        cyc(ins, 0, 1, 0, 0, o(0, 2'b10, 0, 12'h200, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0, 0), "brn_taken");

        ins = mk(OP_JMP, 3'd0, 3'd5, 3'd0);
        cyc(ins, 0, 0, 0, 0, INFV, "jmp_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b11, 0, 12'h050, 0, 2'b00, 0, 4'b0000, 1, 0, 0, 0, 0), "jmp");
        ins = mk(OP_LDI, 3'd5, 3'd0, 3'd7);
        cyc(ins, 0, 0, 0, 0, INFV, "ldi_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b01, 1, 12'h507, 0, 2'b00, 1, 4'b1100, 1, 0, 0, 0, 0), "ldi");
        ins = mk(OP_XXL, 3'd0, 3'd0, 3'd0);
        cyc(ins, 0, 0, 0, 0, INFV, "xxl_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'b1110, 1, 0, 0, 0, 0), "xxl");

        // LD: waits through MWT count 0..2, ready arrives in the last allowed cycle.
        ins = mk(OP_LD, 3'd4, 3'd6, 3'd0);
        cyc(ins, 0, 0, 0, 0, INFV, "ld_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h460, 1, 2'b01, 0, 4'b0000, 1, 0, 0, 0, 0), "ld_ex0_wait");
        for (int i = 0; i < 3; i++)
            cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h460, 1, 2'b01, 0, 4'b0000, 1, 0, 0, 0, 0), "ld_mwt");
        cyc(ins, 0, 0, 1, 0, o(0, 2'b01, 1, 12'h460, 1, 2'b01, 0, 4'b0000, 1, 0, 0, 0, 0), "ld_ready_last");

        ins = mk(OP_IOR, 3'd3, 3'd1, 3'd0);
        cyc(ins, 0, 0, 1, 0, INFV, "ior_inf");
        cyc(ins, 0, 0, 1, 0, o(0, 2'b01, 1, 12'h310, 1, 2'b10, 0, 4'b0001, 1, 1, 0, 0, 0), "ior_zero_wait");

        ins = mk(OP_ST, 3'd0, 3'd2, 3'd6);
        cyc(ins, 0, 0, 0, 0, INFV, "st_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h026, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0), "st_ex0");
        for (int i = 0; i < 4; i++)
            cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h026, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0), "st_mwt");
        cyc(ins, 0, 0, 0, 0, HLTE, "st_timeout_hlt");
        cyc(ins, 0, 0, 0, 0, HLTE, "st_hlt_hold");
        cyc(ins, 0, 0, 0, 1, HLTE, "st_hlt_run");

        ins = mk(OP_IOW, 3'd0, 3'd1, 3'd2);
        cyc(ins, 0, 0, 0, 0, INFV, "resume_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h012, 1, 2'b00, 0, 4'b0001, 0, 1, 0, 0, 0), "iow_wait");
        cyc(ins, 0, 0, 1, 0, o(0, 2'b01, 0, 12'h012, 1, 2'b00, 0, 4'b0001, 0, 1, 0, 0, 0), "iow_done");

        ins = mk(OP_HAL, 3'd0, 3'd0, 3'd0);
        cyc(ins, 0, 0, 0, 0, INFV, "hal_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h000, 0, 2'b00, 0, 4'b1111, 1, 0, 0, 0, 0), "hal_ex0");
        for (int i = 0; i < 4; i++)
            cyc(ins, 0, 0, 0, 0, HLTV, "hlt_hold");
        cyc(ins, 0, 0, 0, 1, HLTV, "hlt_run");

        ins = mk(OP_ST, 3'd1, 3'd1, 3'd1);
        cyc(ins, 0, 0, 0, 0, INFV, "st2_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h111, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0), "st2_ex0");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b00, 0, 12'h111, 1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0), "st2_mwt");
        rst_n = 1'b0;
        cyc(ins, 0, 0, 0, 0, RSTV, "reset_mid_mwt");
        cyc(ins, 0, 0, 0, 0, RSTV, "reset_held");
        rst_n = 1'b1;
        ins = mk(OP_ADD, 3'd1, 3'd2, 3'd3);
        cyc(ins, 0, 0, 0, 0, RSTV, "rst_state2");
        cyc(ins, 0, 0, 0, 0, INFV, "post_reset_inf");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b01, 1, 12'h123, 0, 2'b00, 0, 4'b0010, 1, 0, 0, 0, 0), "post_reset_add");

`ifdef CU_IRQ_EN
        bus.irq_in = 1'b1;
        cyc(ins, 0, 0, 0, 0, RSTV, "irq_inf_divert");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b11, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0, 1), "irq_ack");
        cyc(ins, 0, 0, 0, 0, INFV, "irq_inf_masked");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b01, 1, 12'h123, 0, 2'b00, 0, 4'b0010, 1, 0, 0, 0, 0), "irq_add_ex0");
        cyc(ins, 0, 0, 0, 0, RSTV, "irq_inf_again");
        cyc(ins, 0, 0, 0, 0, o(0, 2'b11, 0, 12'h000, 0, 2'b00, 0, 4'h0, 1, 0, 0, 0, 1), "irq_ack2");
        bus.irq_in = 1'b0;
        cyc(ins, 0, 0, 0, 0, INFV, "irq_done_inf");
`endif

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
